rv32_inst_encoder: RTL and testbench

- Sequential RV32I instruction encoder and program writer; the inverse of the decode-side immediate generator.
- Accepts decoded fields plus an immediate or a branch/jump target through a valid/ready handshake.
- Scatters the immediate into the R/I/S/SB/U/UJ bit layout, range-checks it, and writes the 32-bit word into instruction memory at an internal PC.
- Used by the boot/test loader to fill instruction memory before the core runs.

---
 rtl/rv32_inst_encoder.sv | 130 +++++++++++++
 tb/tb_rv32_inst_encoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_inst_encoder.sv
// rv32_inst_encoder: packs decoded RV32I fields into instruction words and writes them to instruction memory at a running PC
module rv32_inst_encoder #(
    parameter int ADDR_W = 10,
    parameter logic [ADDR_W-1:0] BASE_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt,
    input  logic [6:0]        req_opcode,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [31:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       wr_count
);
    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        fmt, f3;
    logic [6:0]        op, f7;
    logic [4:0]        rd, rs1, rs2;
    logic [31:0]       imm, off, word;
    logic [1:0]        code;
    logic              imm_ok, sb_ok, uj_ok;
    assign off       = imm - 32'(pc);
    assign imm_ok    = &imm[31:11] | ~|imm[31:11];
    assign sb_ok     = &off[31:12] | ~|off[31:12];
    assign uj_ok     = &off[31:20] | ~|off[31:20];
    assign req_ready = state == IDLE && !pc_load;
    assign mem_addr  = pc;
    assign pc_out    = pc;
    always_comb begin
        word = '0;
        code = 2'd0;
        case (fmt)
            3'd0: word = {f7, rs2, rs1, f3, rd, op};
            3'd1: begin
                word = {imm[11:0], rs1, f3, rd, op};
                code = imm_ok ? 2'd0 : 2'd1;
            end
            3'd2: begin
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                code = imm_ok ? 2'd0 : 2'd1;
            end
            3'd3: begin
                word = {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], op};
                code = off[0] ? 2'd2 : sb_ok ? 2'd0 : 2'd1;
            end
            3'd4: begin
                word = {imm[31:12], rd, op};
                code = |imm[11:0] ? 2'd1 : 2'd0;
            end
            3'd5: begin
                word = {off[20], off[10:1], off[11], off[19:12], rd, op};
                code = off[0] ? 2'd2 : uj_ok ? 2'd0 : 2'd1;
            end
            default: code = 2'd3;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= BASE_PC;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            err       <= 1'b0;
            err_code  <= '0;
            wr_count  <= '0;
            fmt       <= '0;
            op        <= '0;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            f3        <= '0;
            f7        <= '0;
            imm       <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pc_load) pc <= pc_load_val & ~ADDR_W'(3);
                    else if (req_valid) begin
                        fmt   <= req_fmt;
                        op    <= req_opcode;
                        rd    <= req_rd;
                        rs1   <= req_rs1;
                        rs2   <= req_rs2;
                        f3    <= req_funct3;
                        f7    <= req_funct7;
                        imm   <= req_imm;
                        state <= ENC;
                    end
                end
                ENC: begin
                    if (code != 2'd0) begin
                        err      <= 1'b1;
                        err_code <= code;
                        state    <= IDLE;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_wdata <= word;
                        state     <= WR;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        pc       <= pc + ADDR_W'(4);
                        wr_count <= wr_count + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_inst_encoder.sv
// tb_rv32_inst_encoder: directed and random requests checked against a transaction-level encoding model
module tb_rv32_inst_encoder;
    logic        clk = 1'b0;
    logic        rst_n, pc_load, req_valid, req_ready, mem_we, mem_ack, err;
    logic [9:0]  pc_load_val, mem_addr, pc_out;
    logic [2:0]  req_fmt, req_funct3;
    logic [6:0]  req_opcode, req_funct7;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm, mem_wdata;
    logic [1:0]  err_code;
    logic [15:0] wr_count;
    int          checks = 0, failures = 0;
    logic [9:0]  m_pc = '0;
    logic [15:0] m_cnt = '0;
    logic [1:0]  m_code = '0;
    logic        exp_we = 1'b0, exp_err = 1'b0, exp_idle = 1'b1;
    logic [9:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;

    rv32_inst_encoder #(.ADDR_W(10), .BASE_PC(10'd0)) dut (
        .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
        .req_opcode(req_opcode), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .pc_out(pc_out), .err(err), .err_code(err_code), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Encoding from the ISA rules: signed ranges and shifted bit groups
    function automatic void model(input int fmt, input logic [31:0] op, rd, rs1, rs2, f3, f7, imm,
                                  input logic [9:0] pc, output logic [31:0] w, output int code);
        logic [31:0] off = imm - 32'(pc);
        int si = $signed(imm);
        int so = $signed(off);
        w = 0;
        code = 0;
        case (fmt)
            0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            1: begin
                code = (si < -2048 || si > 2047) ? 1 : 0;
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            2: begin
                code = (si < -2048 || si > 2047) ? 1 : 0;
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((imm & 32'h1F) << 7) | op;
            end
            3: begin
                code = (so % 2 != 0) ? 2 : (so < -4096 || so > 4094) ? 1 : 0;
                w = (((off >> 12) & 1) << 31) | (((off >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((off >> 1) & 32'hF) << 8)
                    | (((off >> 11) & 1) << 7) | op;
            end
            4: begin
                code = (imm % 4096 != 0) ? 1 : 0;
                w = (imm & 32'hFFFFF000) | (rd << 7) | op;
            end
            5: begin
                code = (so % 2 != 0) ? 2 : (so < -(1 << 20) || so > (1 << 20) - 2) ? 1 : 0;
                w = (((off >> 20) & 1) << 31) | (((off >> 1) & 32'h3FF) << 21)
                    | (((off >> 11) & 1) << 20) | (off & 32'h000FF000) | (rd << 7) | op;
            end
            default: code = 3;
        endcase
    endfunction

    always @(negedge clk) begin
        chk("pc_out", 32'(pc_out), 32'(m_pc));
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("err", 32'(err), 32'(exp_err));
        chk("err_code", 32'(err_code), 32'(m_code));
        chk("req_ready", 32'(req_ready), 32'(exp_idle && !pc_load));
        if (exp_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wdata", mem_wdata, exp_data);
        end
    end

    // Called #1 after a rising edge in IDLE; returns #1 after the edge that ends the transaction
    task automatic send(input int fmt, input logic [31:0] op, rd, rs1, rs2, f3, f7, imm, input int dly);
        logic [31:0] w;
        int code;
        model(fmt, op, rd, rs1, rs2, f3, f7, imm, m_pc, w, code);
        req_valid = 1'b1;
        req_fmt = 3'(fmt);
        req_opcode = op[6:0];
        req_rd = rd[4:0];
        req_rs1 = rs1[4:0];
        req_rs2 = rs2[4:0];
        req_funct3 = f3[2:0];
        req_funct7 = f7[6:0];
        req_imm = imm;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_imm = $urandom;
        exp_idle = 1'b0;
        @(posedge clk); #1;
        if (code != 0) begin
            exp_err = 1'b1;
            m_code = 2'(code);
            exp_idle = 1'b1;
            @(posedge clk); #1;
            exp_err = 1'b0;
            return;
        end
        exp_we = 1'b1;
        exp_addr = m_pc;
        exp_data = w;
        if (dly < 0) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_pc", 32'(pc_out), 0);
            m_pc = '0;
            m_cnt = '0;
            m_code = '0;
            exp_we = 1'b0;
            exp_idle = 1'b1;
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end
        repeat (dly) begin
            @(posedge clk); #1;
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        exp_we = 1'b0;
        exp_idle = 1'b1;
        m_pc = m_pc + 10'd4;
        m_cnt = m_cnt + 16'd1;
    endtask

    task automatic load_pc(input logic [9:0] val);
        pc_load = 1'b1;
        pc_load_val = val;
        req_valid = 1'b1;
        req_fmt = 3'd0;
        req_opcode = 7'h33;
        @(posedge clk); #1;
        pc_load = 1'b0;
        req_valid = 1'b0;
        m_pc = {val[9:2], 2'b00};
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] w, imm;
        int code, fmt;
        rst_n = 1'b0;
        pc_load = 1'b0;
        pc_load_val = '0;
        req_valid = 1'b0;
        req_fmt = '0;
        req_opcode = '0;
        req_rd = '0;
        req_rs1 = '0;
        req_rs2 = '0;
        req_funct3 = '0;
        req_funct7 = '0;
        req_imm = '0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        model(1, 32'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 10'h0, w, code);
        chk("pin_I", w, 32'hFFF00093);
        model(2, 32'h23, 0, 1, 2, 2, 0, 32'd8, 10'h0, w, code);
        chk("pin_S", w, 32'h0020A423);
        model(4, 32'h37, 5, 0, 0, 0, 0, 32'h12345000, 10'h0, w, code);
        chk("pin_U", w, 32'h123452B7);
        model(3, 32'h63, 0, 0, 0, 0, 0, 32'h8, 10'h10, w, code);
        chk("pin_SB", w, 32'hFE000CE3);
        model(5, 32'h6F, 0, 0, 0, 0, 0, 32'h800, 10'h0, w, code);
        chk("pin_UJ", w, 32'h0010006F);
        model(3, 32'h63, 0, 0, 0, 0, 0, 32'h11, 10'h10, w, code);
        chk("pin_SB_mis", 32'(code), 2);
        send(1, 32'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 0);
        chk("plan1_pc", 32'(pc_out), 4);
        chk("plan1_cnt", 32'(wr_count), 1);
        send(2, 32'h23, 0, 1, 2, 2, 0, 32'd8, 0);
        send(4, 32'h37, 5, 0, 0, 0, 0, 32'h12345000, 1);
        load_pc(10'h10);
        send(3, 32'h63, 0, 0, 0, 0, 0, 32'h8, 0);
        load_pc(10'h0);
        send(5, 32'h6F, 0, 0, 0, 0, 0, 32'h800, 0);
        send(1, 32'h13, 1, 0, 0, 0, 0, 32'h800, 0);
        chk("plan5_code1", 32'(err_code), 1);
        load_pc(10'h10);
        send(3, 32'h63, 0, 0, 0, 0, 0, 32'h11, 0);
        chk("plan5_code2", 32'(err_code), 2);
        send(7, 32'h13, 0, 0, 0, 0, 0, 32'h0, 0);
        chk("plan5_code3", 32'(err_code), 3);
        send(0, 32'h33, 3, 4, 5, 7, 32'h20, 32'h0, 3);
        load_pc(10'h3FF);
        send(1, 32'h13, 2, 3, 0, 0, 0, 32'h7FF, 2);
        chk("wrap_pc", 32'(pc_out), 0);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) load_pc(10'($urandom));
            fmt = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8400)) - 32'd4200;
                2: imm = 32'(m_pc) + 32'($urandom_range(0, 9000)) - 32'd4500;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            if (fmt >= 3 && fmt != 4 && $urandom_range(0, 2) != 0) imm = imm & ~32'h1;
            send(fmt, 32'($urandom_range(0, 127)), 32'($urandom_range(0, 31)), 32'($urandom_range(0, 31)),
                 32'($urandom_range(0, 31)), 32'($urandom_range(0, 7)), 32'($urandom_range(0, 127)),
                 imm, $urandom_range(0, 3));
        end
        load_pc(10'h20);
        send(1, 32'h13, 1, 0, 0, 0, 0, 32'h5, -1);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
